// File: rtl/divisor_arbitro.sv
// Round-robin front end that shares one fixed-latency pipelined divider among NREQ requesters,
// tagging each issued slot so results return to their owner; zero denominators bypass the divider.
module divisor_arbitro #(
  parameter int SIZE = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*SIZE-1:0] NUM_IN,
  input  logic [NREQ*SIZE-1:0] DEN_IN,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      RESP_VALID,
  output logic [SIZE-1:0]      COC_OUT,
  output logic [SIZE-1:0]      RES_OUT,
  output logic                 DZ_OUT,
  output logic                 DIV_START,
  output logic [SIZE-1:0]      DIV_NUM,
  output logic [SIZE-1:0]      DIV_DEN,
  input  logic [SIZE-1:0]      DIV_COC,
  input  logic [SIZE-1:0]      DIV_RES,
  input  logic                 DIV_DONE,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic            valid;
    logic            dz;
    logic [IDW-1:0]  id;
    logic [SIZE-1:0] num;
  } tag_t;

  logic [IDW-1:0]  ptr_reg;
  logic [IDW-1:0]  ptr_next;
  logic [IDW-1:0]  cand_id [NREQ];
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [SIZE-1:0] win_num;
  logic [SIZE-1:0] win_den;

  logic            div_start_reg;
  logic [SIZE-1:0] div_num_reg;
  logic [SIZE-1:0] div_den_reg;

  tag_t            tag_reg [LAT+1];
  tag_t            tag_next;
  tag_t            head;
  logic            head_ok;
  logic [LAT:0]    stage_valid;

  logic [NREQ-1:0] resp_valid_reg;
  logic [SIZE-1:0] coc_reg;
  logic [SIZE-1:0] res_reg;
  logic            dz_reg;
  logic            err_reg;

  // Search order starts at the pointer and wraps: cand_id[k] = (ptr + k) mod NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum = {1'b0, ptr_reg} + (IDW+1)'(gi);
    assign cand_id[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
  end

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && REQ[cand_id[k]]) begin
        win_found = 1'b1;
        win_id    = cand_id[k];
      end
    end
  end

  assign win_num  = NUM_IN[win_id*SIZE +: SIZE];
  assign win_den  = DEN_IN[win_id*SIZE +: SIZE];
  assign ptr_next = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
  assign GNT      = (win_found && RST_N) ? (NREQ'(1) << win_id) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_reg       <= '0;
      div_start_reg <= 1'b0;
      div_num_reg   <= '0;
      div_den_reg   <= '0;
    end else begin
      div_start_reg <= win_found && (win_den != '0);
      if (win_found) begin
        ptr_reg     <= ptr_next;
        div_num_reg <= win_num;
        div_den_reg <= win_den;
      end
    end
  end

  // Bypass slots still occupy a tag stage so responses keep grant order.
  always_comb begin
    tag_next       = '0;
    tag_next.valid = win_found;
    tag_next.dz    = (win_den == '0);
    tag_next.id    = win_id;
    tag_next.num   = win_num;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tag_reg[0] <= '0;
    else        tag_reg[0] <= tag_next;
  end

  for (genvar gi = 1; gi <= LAT; gi++) begin : g_tag
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) tag_reg[gi] <= '0;
      else        tag_reg[gi] <= tag_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi <= LAT; gi++) begin : g_busy
    assign stage_valid[gi] = tag_reg[gi].valid;
  end

  // The head stage lines up with the cycle the divider must raise DIV_DONE.
  assign head    = tag_reg[LAT];
  assign head_ok = head.valid && !head.dz;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_valid_reg <= '0;
      coc_reg        <= '0;
      res_reg        <= '0;
      dz_reg         <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      resp_valid_reg <= head.valid ? (NREQ'(1) << head.id) : '0;
      if (head.valid) begin
        if (head.dz) begin
          coc_reg <= '1;
          res_reg <= head.num;
          dz_reg  <= 1'b1;
        end else begin
          coc_reg <= DIV_COC;
          res_reg <= DIV_RES;
          dz_reg  <= 1'b0;
        end
      end
      if (DIV_DONE != head_ok) err_reg <= 1'b1;
    end
  end

  assign DIV_START  = div_start_reg;
  assign DIV_NUM    = div_num_reg;
  assign DIV_DEN    = div_den_reg;
  assign RESP_VALID = resp_valid_reg;
  assign COC_OUT    = coc_reg;
  assign RES_OUT    = res_reg;
  assign DZ_OUT     = dz_reg;
  assign ERR        = err_reg;
  assign BUSY       = (|stage_valid) || (|resp_valid_reg);

endmodule

// File: tb/tb_divisor_arbitro.sv
// Bench for divisor_arbitro: behavioural divider model on the divider side, queue-based
// reference model of arbitration and response ordering on the requester side.
module tb_divisor_arbitro;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 8;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic [NREQ-1:0]      REQ;
  logic [NREQ*SIZE-1:0] NUM_IN;
  logic [NREQ*SIZE-1:0] DEN_IN;
  logic [NREQ-1:0]      GNT;
  logic [NREQ-1:0]      RESP_VALID;
  logic [SIZE-1:0]      COC_OUT;
  logic [SIZE-1:0]      RES_OUT;
  logic                 DZ_OUT;
  logic                 DIV_START;
  logic [SIZE-1:0]      DIV_NUM;
  logic [SIZE-1:0]      DIV_DEN;
  logic [SIZE-1:0]      DIV_COC;
  logic [SIZE-1:0]      DIV_RES;
  logic                 DIV_DONE;
  logic                 BUSY;
  logic                 ERR;

  divisor_arbitro #(.SIZE(SIZE), .NREQ(NREQ), .LAT(LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .NUM_IN(NUM_IN), .DEN_IN(DEN_IN),
    .GNT(GNT), .RESP_VALID(RESP_VALID), .COC_OUT(COC_OUT), .RES_OUT(RES_OUT),
    .DZ_OUT(DZ_OUT), .DIV_START(DIV_START), .DIV_NUM(DIV_NUM), .DIV_DEN(DIV_DEN),
    .DIV_COC(DIV_COC), .DIV_RES(DIV_RES), .DIV_DONE(DIV_DONE), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Divider model: fixed LAT-cycle delay line, shares RST_N.
  logic [LAT-1:0]  pv;
  logic [SIZE-1:0] pq [LAT];
  logic [SIZE-1:0] pr [LAT];
  logic            kill_done = 1'b0;
  logic            spur_done = 1'b0;

  assign DIV_DONE = (pv[LAT-1] & ~kill_done) | spur_done;
  assign DIV_COC  = pq[LAT-1];
  assign DIV_RES  = pr[LAT-1];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        pq[i] <= '0;
        pr[i] <= '0;
      end
    end else begin
      pv    <= {pv[LAT-2:0], DIV_START};
      pq[0] <= (DIV_DEN != 0) ? DIV_NUM / DIV_DEN : '1;
      pr[0] <= (DIV_DEN != 0) ? DIV_NUM % DIV_DEN : DIV_NUM;
      for (int i = 1; i < LAT; i++) begin
        pq[i] <= pq[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end

  // Reference model state
  typedef struct {
    int              g;
    int              due;
    int              id;
    logic [SIZE-1:0] coc;
    logic [SIZE-1:0] res;
    logic            dz;
  } exp_t;

  exp_t            q[$];
  int              ptr_m;
  int              cyc;
  int              errors;
  int              checks;
  int              w;
  logic            err_m;
  logic            prev_gnt;
  logic            prev_start;
  logic [SIZE-1:0] prev_num;
  logic [SIZE-1:0] prev_den;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic set_op(input int i, input int n, input int d);
    NUM_IN[i*SIZE +: SIZE] = SIZE'(n);
    DEN_IN[i*SIZE +: SIZE] = SIZE'(d);
  endtask

  task automatic model_reset();
    q.delete();
    ptr_m      = 0;
    err_m      = 1'b0;
    prev_gnt   = 1'b0;
    prev_start = 1'b0;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_gnt"}, GNT, 0);
    chk({tag, "_resp_valid"}, RESP_VALID, 0);
    chk({tag, "_div_start"}, DIV_START, 0);
    chk({tag, "_dz"}, DZ_OUT, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_coc"}, COC_OUT, 0);
    chk({tag, "_res"}, RES_OUT, 0);
    chk({tag, "_div_num"}, DIV_NUM, 0);
    chk({tag, "_div_den"}, DIV_DEN, 0);
  endtask

  // One clock cycle: inputs are already driven; sample mid low phase, then advance.
  task automatic step(output int win_o);
    int              win;
    logic [NREQ-1:0] gexp;
    logic [NREQ-1:0] oh;
    logic            busy_exp;
    logic            head_ok;
    logic [SIZE-1:0] n;
    logic [SIZE-1:0] d;
    exp_t            e;
    #1;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NREQ;
      if (win < 0 && REQ[idx]) win = idx;
    end
    gexp = '0;
    if (win >= 0) gexp[win] = 1'b1;
    chk("gnt", GNT, gexp);

    busy_exp = 1'b0;
    foreach (q[i]) if (q[i].g < cyc) busy_exp = 1'b1;
    chk("busy", BUSY, busy_exp);

    chk("div_start", DIV_START, prev_start);
    if (prev_gnt) begin
      chk("div_num", DIV_NUM, prev_num);
      chk("div_den", DIV_DEN, prev_den);
    end

    if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      oh = '0;
      oh[e.id] = 1'b1;
      chk("resp_valid", RESP_VALID, oh);
      chk("coc", COC_OUT, e.coc);
      chk("res", RES_OUT, e.res);
      chk("dz", DZ_OUT, e.dz);
      $display("cycle %0d resp id=%0d coc=%0d res=%0d dz=%0b", cyc, e.id, COC_OUT, RES_OUT, DZ_OUT);
    end else begin
      chk("resp_idle", RESP_VALID, 0);
    end
    chk("err", ERR, err_m);

    head_ok = 1'b0;
    foreach (q[i]) if (q[i].due == cyc + 1 && !q[i].dz) head_ok = 1'b1;
    if ((kill_done && head_ok) || (spur_done && !head_ok)) err_m = 1'b1;

    prev_gnt   = 1'b0;
    prev_start = 1'b0;
    if (win >= 0) begin
      n      = NUM_IN[win*SIZE +: SIZE];
      d      = DEN_IN[win*SIZE +: SIZE];
      e.g    = cyc;
      e.due  = cyc + LAT + 2;
      e.id   = win;
      e.dz   = (d == 0);
      e.coc  = (d == 0) ? {SIZE{1'b1}} : n / d;
      e.res  = (d == 0) ? n : n % d;
      q.push_back(e);
      ptr_m      = (win + 1) % NREQ;
      prev_gnt   = 1'b1;
      prev_start = (d != 0);
      prev_num   = n;
      prev_den   = d;
    end
    win_o = win;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic idle(input int ncyc);
    int dummy;
    REQ = '0;
    for (int i = 0; i < ncyc; i++) step(dummy);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    model_reset();
    REQ    = '0;
    NUM_IN = '0;
    DEN_IN = '0;

    // Reset state
    @(negedge CLK);
    #1;
    check_reset_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // All four requesters held high for 8 cycles
    REQ = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NREQ; r++) set_op(r, $urandom_range(0, 255), $urandom_range(1, 255));
      step(w);
      chk("rr_order", w, i % NREQ);
    end
    idle(LAT + 3);

    // Single request 100/7
    set_op(0, 100, 7);
    REQ = 4'b0001;
    step(w);
    idle(LAT + 3);

    // Fairness: REQ0 always high, REQ2 joins at cycle 5
    REQ = 4'b0001;
    for (int i = 0; i < 5; i++) step(w);
    REQ = 4'b0101;
    for (int i = 0; i < 8; i++) step(w);
    idle(LAT + 3);

    // Divide by zero between two normal operations
    set_op(0, 100, 7);
    set_op(1, 55, 0);
    set_op(2, 200, 9);
    REQ = 4'b0001; step(w);
    REQ = 4'b0010; step(w);
    REQ = 4'b0100; step(w);
    idle(LAT + 3);

    // Randomised traffic, requests held until granted
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!REQ[r] && $urandom_range(0, 2) == 0) REQ[r] = 1'b1;
        set_op(r, $urandom_range(0, 255), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255));
      end
      step(w);
      if (w >= 0 && $urandom_range(0, 1) == 1) REQ[w] = 1'b0;
    end
    idle(LAT + 3);

    // Reset with five operations in flight
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < NREQ; r++) set_op(r, $urandom_range(0, 255), $urandom_range(1, 255));
      step(w);
    end
    RST_N = 1'b0;
    #1;
    check_reset_zero("midreset");
    model_reset();
    REQ = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    idle(LAT + 3);
    set_op(3, 250, 13);
    REQ = 4'b1000;
    step(w);
    idle(LAT + 3);

    // Missing DIV_DONE at the head cycle
    set_op(1, 77, 5);
    REQ = 4'b0010;
    step(w);
    idle(LAT);
    kill_done = 1'b1;
    step(w);
    kill_done = 1'b0;
    idle(4);

    // Spurious DIV_DONE while idle
    RST_N = 1'b0;
    #1;
    check_reset_zero("rst2");
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    idle(1);
    spur_done = 1'b1;
    step(w);
    spur_done = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
